// File: rtl/sample_pwm_sink.sv
// Sample FIFO feeding an 8-bit PWM audio DAC; one signed sample is consumed per PWM frame
// and played as an offset-binary duty cycle.
module sample_pwm_sink #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DIV        = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    sample_in,
   input  logic                          sample_valid,
   output logic                          sample_ready,
   input  logic                          clear_underrun,
   output logic                          pwm_out,
   output logic                          frame_start,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned PreW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [PreW-1:0] presc_q, presc_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [7:0]      duty_q, duty_d;
   logic            pwm_q, pwm_d;
   logic            frame_start_q, frame_start_d;
   logic            underrun_q, underrun_d;

   logic tick;
   logic boundary;
   logic push;
   logic pop;

   assign sample_ready = (count_q < CntW'(FIFO_DEPTH));
   assign fifo_count   = count_q;
   assign pwm_out      = pwm_q;
   assign frame_start  = frame_start_q;
   assign underrun     = underrun_q;

   assign tick     = (presc_q == PreW'(DIV - 1));
   assign boundary = tick && (cnt_q == 8'hFF);
   assign push     = sample_valid && sample_ready;
   assign pop      = boundary && (count_q != '0);

   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      presc_d       = presc_q;
      cnt_d         = cnt_q;
      duty_d        = duty_q;
      underrun_d    = underrun_q;
      frame_start_d = boundary;
      // Compare uses the pre-edge counter and duty, hence one clock of output latency.
      pwm_d         = (cnt_q < duty_q);

      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
         duty_d   = mem_q[rd_ptr_q] ^ 8'h80;
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase

      if (tick) begin
         presc_d = '0;
         cnt_d   = cnt_q + 8'd1;
      end else begin
         presc_d = presc_q + PreW'(1);
      end

      // An empty-FIFO boundary takes priority over a clear in the same cycle.
      if (boundary && (count_q == '0)) begin
         underrun_d = 1'b1;
      end else if (clear_underrun) begin
         underrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         presc_q       <= '0;
         cnt_q         <= 8'd0;
         duty_q        <= 8'h80;
         pwm_q         <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         presc_q       <= presc_d;
         cnt_q         <= cnt_d;
         duty_q        <= duty_d;
         pwm_q         <= pwm_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
      end
   end

   // Storage needs no reset: the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= sample_in;
      end
   end

endmodule

// File: tb/tb_sample_pwm_sink.sv
// Drives two sinks (DIV=1 and DIV=2) with shared stimulus and checks each against a
// cycle model whose queue holds the expected duty of every accepted sample.
module tb_sample_pwm_sink;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] sample_in;
   logic       sample_valid;
   logic       clear_underrun;

   logic       pwm_w [2];
   logic       fs_w  [2];
   logic       und_w [2];
   logic       rdy_w [2];
   logic [2:0] cnt_w [2];

   int nvec  = 0;
   int nfail = 0;

   // Model state, one slot per DUT.
   int unsigned cyc      [2];
   int unsigned acc      [2];
   logic [7:0]  duty_m   [2];
   logic        und_m    [2];
   logic        pend_push[2];
   logic [7:0]  pend_smp [2];
   logic        pend_clr [2];
   logic [7:0]  sb0[$];
   logic [7:0]  sb1[$];

   always #5 clk = ~clk;

   sample_pwm_sink #(.FIFO_DEPTH(4), .DIV(1)) u_div1 (
      .clk            (clk),
      .reset          (reset),
      .sample_in      (sample_in),
      .sample_valid   (sample_valid),
      .sample_ready   (rdy_w[0]),
      .clear_underrun (clear_underrun),
      .pwm_out        (pwm_w[0]),
      .frame_start    (fs_w[0]),
      .underrun       (und_w[0]),
      .fifo_count     (cnt_w[0])
   );

   sample_pwm_sink #(.FIFO_DEPTH(4), .DIV(2)) u_div2 (
      .clk            (clk),
      .reset          (reset),
      .sample_in      (sample_in),
      .sample_valid   (sample_valid),
      .sample_ready   (rdy_w[1]),
      .clear_underrun (clear_underrun),
      .pwm_out        (pwm_w[1]),
      .frame_start    (fs_w[1]),
      .underrun       (und_w[1]),
      .fifo_count     (cnt_w[1])
   );

   task automatic check(input int k, input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL u%0d %s: observed %0d expected %0d (t=%0t)", k, tag, obs, exp, $time);
      end
   endtask

   function automatic int unsigned sb_size(input int k);
      return (k == 0) ? sb0.size() : sb1.size();
   endfunction

   task automatic sb_push(input int k, input logic [7:0] v);
      if (k == 0) sb0.push_back(v);
      else        sb1.push_back(v);
   endtask

   task automatic sb_pop(input int k, output logic [7:0] v);
      if (k == 0) v = sb0.pop_front();
      else        v = sb1.pop_front();
   endtask

   // Called each falling edge; accounts for the rising edge that just happened.
   task automatic model_step(input int k, input int unsigned div);
      int unsigned frame;
      logic        exp_pwm;
      logic        bnd;
      logic [7:0]  head;
      frame = 256 * div;
      if (reset) begin
         cyc[k]    = 0;
         acc[k]    = 0;
         duty_m[k] = 8'h80;
         und_m[k]  = 1'b0;
         if (k == 0) sb0.delete();
         else        sb1.delete();
         check(k, "rst_pwm", pwm_w[k], 0);
         check(k, "rst_fs", fs_w[k], 0);
         check(k, "rst_underrun", und_w[k], 0);
         check(k, "rst_count", cnt_w[k], 0);
         check(k, "rst_ready", rdy_w[k], 1);
      end else begin
         exp_pwm = (((cyc[k] % frame) / div) < duty_m[k]);
         cyc[k]++;
         bnd = ((cyc[k] % frame) == 0);
         acc[k] += pwm_w[k];
         check(k, "pwm", pwm_w[k], exp_pwm);
         if (bnd) begin
            check(k, "frame_high", acc[k], duty_m[k] * div);
            acc[k] = 0;
         end
         if (bnd && sb_size(k) == 0) begin
            und_m[k] = 1'b1;
         end else begin
            if (bnd) begin
               sb_pop(k, head);
               duty_m[k] = head;
            end
            if (pend_clr[k]) und_m[k] = 1'b0;
         end
         if (pend_push[k]) sb_push(k, pend_smp[k] ^ 8'h80);
         check(k, "fifo_count", cnt_w[k], sb_size(k));
         check(k, "underrun", und_w[k], und_m[k]);
         check(k, "frame_start", fs_w[k], bnd);
         check(k, "ready", rdy_w[k], sb_size(k) < 4);
      end
      pend_push[k] = sample_valid && (sb_size(k) < 4);
      pend_smp[k]  = sample_in;
      pend_clr[k]  = clear_underrun;
   endtask

   always @(negedge clk) begin
      model_step(0, 1);
      model_step(1, 2);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [7:0] v);
      sample_valid = 1'b1;
      sample_in    = v;
      step(1);
      sample_valid = 1'b0;
   endtask

   // Advance until the edge just taken leaves DUT k at frame phase ph.
   task automatic to_phase(input int k, input int unsigned ph);
      int unsigned frame;
      bit          hit;
      frame = (k == 0) ? 256 : 512;
      hit   = 0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         step(1);
         if (((cyc[k] + 1) % frame) == ph) hit = 1;
      end
      if (!hit) begin
         nvec++;
         nfail++;
         $error("FAIL u%0d phase_timeout: observed no phase %0d expected within 2000 cycles",
                k, ph);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check(0, "async_pwm", pwm_w[0], 0);
      check(1, "async_pwm", pwm_w[1], 0);
      check(0, "async_count", cnt_w[0], 0);
      check(1, "async_count", cnt_w[1], 0);
      @(negedge clk);
      @(negedge clk);
      #1 reset = 1'b0;
      step(1);
   endtask

   initial begin
      reset          = 1'b1;
      sample_in      = 8'h00;
      sample_valid   = 1'b0;
      clear_underrun = 1'b0;
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;
      step(1);

      // Reset mid-run with samples buffered
      step(40);
      push(8'h11);
      push(8'h22);
      step(10);
      do_reset();

      // Conversion: -128, 0, +127 queued in frame 0
      push(8'h80);
      push(8'h00);
      push(8'h7F);
      check(0, "count3", cnt_w[0], 3);
      for (int f = 1; f <= 3; f++) begin
         to_phase(0, 0);
         check(0, "fs_pulse", fs_w[0], 1);
      end
      step(1);
      check(0, "fs_drop", fs_w[0], 0);

      // Backpressure
      sample_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sample_in = 8'($urandom);
         step(1);
      end
      check(0, "full_count", cnt_w[0], 4);
      check(0, "full_ready", rdy_w[0], 0);
      sample_in = 8'h33;
      to_phase(0, 0);
      check(0, "after_pop_count", cnt_w[0], 3);
      check(0, "after_pop_ready", rdy_w[0], 1);
      sample_in = 8'hC5;
      step(1);
      sample_valid = 1'b0;
      check(0, "refill_count", cnt_w[0], 4);
      for (int f = 0; f < 5; f++) to_phase(0, 0);

      // Underrun, then clear
      clear_underrun = 1'b1;
      step(1);
      clear_underrun = 1'b0;
      check(0, "cleared", und_w[0], 0);
      push(8'h40);
      to_phase(0, 0);
      check(0, "no_underrun", und_w[0], 0);
      to_phase(0, 0);
      check(0, "underrun_set", und_w[0], 1);
      to_phase(0, 0);

      // Push and clear racing an empty boundary
      clear_underrun = 1'b1;
      step(1);
      clear_underrun = 1'b0;
      check(0, "cleared2", und_w[0], 0);
      to_phase(0, 255);
      sample_valid   = 1'b1;
      sample_in      = 8'h5A;
      clear_underrun = 1'b1;
      step(1);
      sample_valid   = 1'b0;
      clear_underrun = 1'b0;
      check(0, "race_underrun", und_w[0], 1);
      check(0, "race_count", cnt_w[0], 1);
      to_phase(0, 0);
      check(0, "race_pop_count", cnt_w[0], 0);
      to_phase(0, 0);

      // DIV=2 frame length, and reset part-way through a frame
      do_reset();
      push(8'h00);
      to_phase(1, 0);
      check(1, "div2_fs", fs_w[1], 1);
      push(8'h7F);
      to_phase(1, 300);
      check(1, "pre_reset_count", cnt_w[1], 1);
      do_reset();
      push(8'h00);
      to_phase(1, 0);
      to_phase(1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/sample_pwm_sink.md
Name: sample_pwm_sink

Overview:
Consumer end of the sound card's 8-bit signed sample stream. It accepts samples over a valid/ready handshake and buffers them in a small FIFO. At each PWM frame boundary it pops one sample and converts it to an offset-binary duty cycle. It then drives a 1-bit PWM audio output for an RC-filtered speaker pin, sitting between the sound_card mixer output and the board pin.

Parameters:
FIFO_DEPTH, 4, sample buffer entries; power of two, minimum 2
DIV, 1, clocks per PWM counter step; minimum 1 (PWM frame = 256*DIV clocks)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
sample_in  input  8  signed two's-complement sample
sample_valid  input  1  sample_in is valid this cycle
sample_ready  output  1  FIFO can accept a sample this cycle
clear_underrun  input  1  synchronous clear of the underrun flag
pwm_out  output  1  PWM audio output, registered
frame_start  output  1  one-cycle pulse in the first cycle of each new PWM frame
underrun  output  1  sticky flag: a frame boundary found the FIFO empty
fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync-safe release) sets:
  - FIFO empty, fifo_count=0
  - prescaler=0, cnt=0, duty=8'h80 (midscale silence)
  - pwm_out=0, frame_start=0, underrun=0
  - sample_ready=1 in the first cycle after reset deasserts.
- Reset mid-frame discards all buffered samples. It also restarts the frame at cnt=0 with duty 8'h80.
- Handshake:
  - sample_ready = (fifo_count < FIFO_DEPTH), combinational from registered count.
  - A push occurs when sample_valid && sample_ready at a clock edge. sample_in is sampled at that edge.
- Tick: prescaler counts 0..DIV-1. tick is high when prescaler==DIV-1. With DIV=1, tick is high every cycle.
- PWM counter: cnt (8-bit) increments on tick and wraps 255->0.
- Frame boundary is the edge where tick && cnt==255:
  - cnt<=0.
  - FIFO non-empty: pop the head and set duty <= head ^ 8'h80. So -128->0, 0->128, +127->255.
  - FIFO empty: duty holds its previous value and underrun<=1.
  - frame_start<=1 for exactly one cycle. It is 0 otherwise, and 0 for the initial frame after reset.
- Output: every clock, pwm_out <= (cnt < duty), giving one clock of latency from cnt/duty.
  - Per frame, pwm_out is high for duty*DIV clocks out of 256*DIV.
  - duty 0 gives never high; duty 255 gives low for DIV clocks per frame.
- Simultaneous events:
  - Push and pop in the same cycle: fifo_count unchanged; the popped entry is the old head.
  - Push when full is refused (ready=0), even if a pop occurs in the same cycle.
  - Pop at a boundary with FIFO empty while a push occurs the same cycle: counts as an underrun. The pushed sample is stored and used at the next boundary.
  - clear_underrun and an underrun event in the same cycle: the set wins, so underrun=1.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH.
- The initial frame after reset plays duty 8'h80. The first pushed sample takes effect at the first boundary, i.e. the edge ending that frame.

Test Plan:
1. Reset values: assert reset mid-run -> pwm_out=0, fifo_count=0, underrun=0, sample_ready=1, frame_start=0; the first frame has pwm_out high for 128 of 256 clocks (DIV=1).
2. Conversion: push 8'h80(-128), 8'h00, 8'h7F in frame 0 -> frames 1/2/3 show 0, 128, and 255 high clocks respectively; frame_start pulses at clocks 256, 512, 768.
3. Backpressure: hold sample_valid=1 with FIFO_DEPTH=4 -> fifo_count reaches 4, sample_ready=0; at the next boundary count drops to 3 and one more push is accepted; no sample is lost or duplicated.
4. Underrun: push one sample 8'h40, then none -> that frame has duty 8'hC0 (192 high clocks); the next boundary sets underrun=1 and repeats duty 192; clear_underrun -> 0 one cycle later.
5. Boundary race: FIFO empty, push at exactly the boundary edge -> underrun=1, fifo_count=1, the sample is applied one frame later.
6. DIV=2: push 8'h00 -> frame length 512 clocks, pwm_out high 256 clocks; async reset at clock 300 of a frame -> counters restart immediately.
